// File: rtl/da_row_sequencer.sv
// Buffers an 8-sample x-vector and runs the DA row engine once per row, streaming tagged results.
// Define DA_SEQ_PINGPONG_EN for two sample banks, so the next block fills while rows run.
module da_row_sequencer #(
    parameter int unsigned NUM_ROWS = 8,
    parameter int unsigned TIMEOUT  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] da_x,
    output logic [4:0]  da_row,
    output logic        da_clr,
    output logic        da_start,
    input  logic        da_done,
    input  logic [18:0] da_y,
    output logic [18:0] out_data,
    output logic [2:0]  out_row,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    localparam logic [2:0]       LastRow = 3'(NUM_ROWS - 1);
    localparam int unsigned      CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StLoad, StClr, StRun, StOut} state_e;

    state_e          state_q, state_d;
    logic [2:0]      wr_idx_q;
    logic [2:0]      row_q, row_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [18:0]     out_data_q, out_data_d;
    logic [2:0]      out_row_q, out_row_d;
    logic            out_last_q, out_last_d;
    logic            err_q, err_d;
    logic            accept, last_accept;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (wr_idx_q == 3'd7);

`ifdef DA_SEQ_PINGPONG_EN
    logic [63:0] bank_q [2];
    logic        fill_q, act_q, fill_full_q;
    logic        swap, full_now;

    // The fill bank is never the active bank once a block has started.
    assign in_ready = !reset && !fill_full_q;
    assign full_now = fill_full_q || last_accept;
    assign da_x     = bank_q[act_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            fill_q      <= 1'b0;
            act_q       <= 1'b0;
            fill_full_q <= 1'b0;
        end else begin
            if (accept) begin
                bank_q[fill_q][{wr_idx_q, 3'b000} +: 8] <= in_data;
            end
            if (swap) begin
                act_q       <= fill_q;
                fill_q      <= ~fill_q;
                fill_full_q <= 1'b0;
            end else if (last_accept) begin
                fill_full_q <= 1'b1;
            end
        end
    end
`else
    logic [63:0] buf_q;

    assign in_ready = !reset && (state_q == StLoad);
    assign da_x     = buf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
        end else if (accept) begin
            buf_q[{wr_idx_q, 3'b000} +: 8] <= in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoad;
            wr_idx_q   <= 3'd0;
            row_q      <= 3'd0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_row_q  <= 3'd0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
            if (accept) begin
                wr_idx_q <= wr_idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_last_d = out_last_q;
        err_d      = err_q;
`ifdef DA_SEQ_PINGPONG_EN
        swap       = 1'b0;
`endif
        case (state_q)
            StLoad: begin
`ifdef DA_SEQ_PINGPONG_EN
                if (full_now) begin
                    swap    = 1'b1;
                    row_d   = 3'd0;
                    state_d = StClr;
                end
`else
                if (last_accept) begin
                    row_d   = 3'd0;
                    state_d = StClr;
                end
`endif
            end
            StClr: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                // A done seen on the first RUN cycle is still taken as valid.
                if (da_done) begin
                    out_data_d = da_y;
                    out_row_d  = row_q;
                    out_last_d = (row_q == LastRow);
                    state_d    = StOut;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StLoad;
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (row_q != LastRow) begin
                        row_d   = row_q + 3'd1;
                        state_d = StClr;
                    end else begin
`ifdef DA_SEQ_PINGPONG_EN
                        if (full_now) begin
                            swap    = 1'b1;
                            row_d   = 3'd0;
                            state_d = StClr;
                        end else begin
                            state_d = StLoad;
                        end
`else
                        state_d = StLoad;
`endif
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // The engine is held cleared for as long as the sequencer is in reset.
    assign da_clr    = reset || (state_q == StClr);
    assign da_start  = !reset && (state_q == StRun);
    assign out_valid = !reset && (state_q == StOut);
    assign da_row    = {2'b00, row_q};
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_da_row_sequencer.sv
// Bench for da_row_sequencer: engine model plus FIFO-of-expected-rows reference.
// Instance 0 uses NUM_ROWS = 8, instance 1 uses NUM_ROWS = 2.
module tb_da_row_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data   [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] da_x      [2];
    logic [4:0]  da_row    [2];
    logic        da_clr    [2];
    logic        da_start  [2];
    logic        da_done   [2];
    logic [18:0] da_y      [2];
    logic [18:0] out_data  [2];
    logic [2:0]  out_row   [2];
    logic        out_last  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        err       [2];

    always #5 clk = ~clk;

    da_row_sequencer #(.NUM_ROWS(8), .TIMEOUT(31)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .da_x(da_x[0]), .da_row(da_row[0]), .da_clr(da_clr[0]),
        .da_start(da_start[0]), .da_done(da_done[0]), .da_y(da_y[0]),
        .out_data(out_data[0]), .out_row(out_row[0]), .out_last(out_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .err(err[0])
    );

    da_row_sequencer #(.NUM_ROWS(2), .TIMEOUT(31)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .da_x(da_x[1]), .da_row(da_row[1]), .da_clr(da_clr[1]),
        .da_start(da_start[1]), .da_done(da_done[1]), .da_y(da_y[1]),
        .out_data(out_data[1]), .out_row(out_row[1]), .out_last(out_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .err(err[1])
    );

    int d_mat [8][8];
    int eng_lat = 10;
    int eng_cnt [2];

    // Engine: Y = D[row] . x, done visible on the eng_lat-th RUN cycle; eng_lat = 0 never finishes.
    function automatic logic [18:0] eng_y(input logic [63:0] x, input logic [4:0] row);
        int s = 0;
        for (int j = 0; j < 8; j++) s += d_mat[row[2:0]][j] * int'($signed(x[8*j +: 8]));
        return s[18:0];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (da_clr[k]) begin
                eng_cnt[k] <= 0;
                da_done[k] <= 1'b0;
                da_y[k]    <= '0;
            end else if (da_start[k] && !da_done[k]) begin
                eng_cnt[k] <= eng_cnt[k] + 1;
                if (eng_lat != 0 && eng_cnt[k] + 2 >= eng_lat) begin
                    da_done[k] <= 1'b1;
                    da_y[k]    <= eng_y(da_x[k], da_row[k]);
                end
            end
        end
    end

    typedef struct packed {
        logic [18:0] d;
        logic [2:0]  r;
        logic        l;
    } exp_t;

    exp_t       exp_mem [2][64];
    int         exp_wr [2];
    int         exp_rd [2];
    logic [7:0] smp [2][8];
    int         smp_n [2];
    int         acc [2];
    int         hs_n [2];
    int         hs_cyc [2][16];
    int         nr [2];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ref_y(input int k, input int r);
        int s = 0;
        for (int j = 0; j < 8; j++) s += d_mat[r][j] * int'($signed(smp[k][j]));
        return s[18:0];
    endfunction

    // One clock: observe handshakes at the negedge, return 1 time unit after the posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (in_valid[k] && in_ready[k]) begin
                smp[k][smp_n[k]] = in_data[k];
                smp_n[k]++;
                acc[k]++;
                if (smp_n[k] == 8) begin
                    for (int r = 0; r < nr[k]; r++) begin
                        e.d = ref_y(k, r);
                        e.r = 3'(r);
                        e.l = (r == nr[k] - 1);
                        exp_mem[k][exp_wr[k] % 64] = e;
                        exp_wr[k]++;
                    end
                    smp_n[k] = 0;
                end
            end
            if (out_valid[k] && out_ready[k]) begin
                if (exp_rd[k] == exp_wr[k]) begin
                    chk("unexpected_out_valid", 64'(out_valid[k]), 64'(0));
                end else begin
                    e = exp_mem[k][exp_rd[k] % 64];
                    chk("out_data", 64'(out_data[k]), 64'(e.d));
                    chk("out_row", 64'(out_row[k]), 64'(e.r));
                    chk("out_last", 64'(out_last[k]), 64'(e.l));
                    exp_rd[k]++;
                end
                hs_cyc[k][hs_n[k] % 16] = cyc;
                hs_n[k]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed_block(input int k, input logic [7:0] v [8], input bit gaps);
        int a;
        int n;
        for (int i = 0; i < 8; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                in_valid[k] = 1'b0;
                cycle();
            end
            in_valid[k] = 1'b1;
            in_data[k]  = v[i];
            a = acc[k];
            n = 0;
            while (acc[k] == a && n < 300) begin
                cycle();
                n++;
            end
            if (acc[k] == a) chk("sample_accept_timeout", 64'(acc[k] - a), 64'(1));
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (exp_rd[k] != exp_wr[k] && n < 2000) begin
            cycle();
            n++;
        end
        chk("drain_pending_rows", 64'(exp_wr[k] - exp_rd[k]), 64'(0));
    endtask

    task automatic rand_d();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) d_mat[r][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin : main
        logic [7:0] v [8];
        logic [7:0] pv [16];
        logic [18:0] hold_d;
        int n;
        int i;
        int a;
        int base;

        nr[0] = 8;
        nr[1] = 2;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) d_mat[r][j] = (r == j) ? r + 1 : 0;

        // Reset values while reset is held.
        cycle();
        cycle();
        chk("rst_in_ready", 64'(in_ready[0]), 64'(0));
        chk("rst_out_valid", 64'(out_valid[0]), 64'(0));
        chk("rst_out_data", 64'(out_data[0]), 64'(0));
        chk("rst_out_row", 64'(out_row[0]), 64'(0));
        chk("rst_out_last", 64'(out_last[0]), 64'(0));
        chk("rst_err", 64'(err[0]), 64'(0));
        chk("rst_da_start", 64'(da_start[0]), 64'(0));
        chk("rst_da_x", da_x[0], 64'(0));
        chk("rst_da_row", 64'(da_row[0]), 64'(0));
        chk("rst_da_clr", 64'(da_clr[0]), 64'(1));
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(in_ready[0]), 64'(1));
        chk("da_clr_after_reset", 64'(da_clr[0]), 64'(0));

        // Samples 1..8, identity-scaled D, row spacing 12 cycles.
        for (int j = 0; j < 8; j++) v[j] = 8'(j + 1);
        base = hs_n[0];
        feed_block(0, v, 1'b0);
        drain(0);
        chk("rows_per_block", 64'(hs_n[0] - base), 64'(8));
        for (int r = 1; r < 8; r++)
            chk("row_spacing", 64'(hs_cyc[0][(base + r) % 16] - hs_cyc[0][(base + r - 1) % 16]),
                64'(12));

        // Random D and samples; stall output for 20 cycles on row 3.
        rand_d();
        for (int j = 0; j < 8; j++) v[j] = 8'($urandom_range(0, 255));
        feed_block(0, v, 1'b1);
        n = 0;
        while (!(out_valid[0] && out_row[0] == 3'd3) && n < 300) begin
            cycle();
            n++;
        end
        out_ready[0] = 1'b0;
        hold_d = exp_mem[0][exp_rd[0] % 64].d;
        for (int c = 0; c < 20; c++) begin
            chk("stall_out_valid", 64'(out_valid[0]), 64'(1));
            chk("stall_out_row", 64'(out_row[0]), 64'(3));
            chk("stall_out_data", 64'(out_data[0]), 64'(hold_d));
            chk("stall_da_start", 64'(da_start[0]), 64'(0));
            chk("stall_da_clr", 64'(da_clr[0]), 64'(0));
`ifndef DA_SEQ_PINGPONG_EN
            chk("stall_in_ready", 64'(in_ready[0]), 64'(0));
`endif
            cycle();
        end
        out_ready[0] = 1'b1;
        drain(0);

        // Engine never finishes: 31 RUN cycles, then err and back to LOAD.
        eng_lat = 0;
        for (int j = 0; j < 8; j++) v[j] = 8'($urandom_range(0, 255));
        feed_block(0, v, 1'b0);
        n = 0;
        while (!da_start[0] && n < 20) begin
            cycle();
            n++;
        end
        n = 0;
        while (da_start[0] && n < 100) begin
            if (n == 0) chk("err_before_timeout", 64'(err[0]), 64'(0));
            n++;
            cycle();
        end
        chk("timeout_run_cycles", 64'(n), 64'(31));
        chk("timeout_err", 64'(err[0]), 64'(1));
        chk("timeout_in_ready", 64'(in_ready[0]), 64'(1));
        exp_rd[0] = exp_wr[0];
        eng_lat = 10;
        for (int j = 0; j < 8; j++) v[j] = 8'($urandom_range(0, 255));
        feed_block(0, v, 1'b1);
        drain(0);
        chk("err_sticky", 64'(err[0]), 64'(1));

        // Reset during RUN of row 5.
        for (int j = 0; j < 8; j++) v[j] = 8'($urandom_range(0, 255));
        feed_block(0, v, 1'b0);
        n = 0;
        while (!(da_start[0] && da_row[0] == 5'd5) && n < 300) begin
            cycle();
            n++;
        end
        chk("reached_row5_run", 64'(da_row[0]), 64'(5));
        reset = 1'b1;
        cycle();
        chk("mid_rst_out_valid", 64'(out_valid[0]), 64'(0));
        chk("mid_rst_out_data", 64'(out_data[0]), 64'(0));
        chk("mid_rst_out_row", 64'(out_row[0]), 64'(0));
        chk("mid_rst_err", 64'(err[0]), 64'(0));
        chk("mid_rst_da_start", 64'(da_start[0]), 64'(0));
        chk("mid_rst_da_x", da_x[0], 64'(0));
        chk("mid_rst_da_row", 64'(da_row[0]), 64'(0));
        chk("mid_rst_da_clr", 64'(da_clr[0]), 64'(1));
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_rd[k] = exp_wr[k];
            smp_n[k]  = 0;
        end
        #1;
        chk("post_rst_in_ready", 64'(in_ready[0]), 64'(1));
        for (int j = 0; j < 8; j++) v[j] = 8'($urandom_range(0, 255));
        feed_block(0, v, 1'b1);
        drain(0);

        // NUM_ROWS = 2 instance, all samples -128.
        rand_d();
        for (int j = 0; j < 8; j++) v[j] = 8'h80;
        base = hs_n[1];
        feed_block(1, v, 1'b0);
        drain(1);
        chk("nr2_row_count", 64'(hs_n[1] - base), 64'(2));

`ifdef DA_SEQ_PINGPONG_EN
        // Back-to-back blocks: second block fills during the first block's rows.
        rand_d();
        for (int j = 0; j < 16; j++) pv[j] = 8'($urandom_range(0, 255));
        i = 0;
        n = 0;
        in_valid[0] = 1'b1;
        while (i < 16 && n < 100) begin
            in_data[0] = pv[i];
            a = acc[0];
            cycle();
            if (acc[0] != a) i++;
            n++;
        end
        in_valid[0] = 1'b0;
        chk("pp_fill_within_20", 64'(n <= 20), 64'(1));
        n = 0;
        while (!(out_valid[0] && out_last[0]) && n < 300) begin
            cycle();
            n++;
        end
        cycle();
        chk("pp_clr_after_last", 64'(da_clr[0]), 64'(1));
        chk("pp_row0_after_last", 64'(da_row[0]), 64'(0));
        drain(0);
`else
        for (int j = 0; j < 16; j++) pv[j] = 8'(j);
        chk("single_bank_idle_ready", 64'(in_ready[0]), 64'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
